// File: rtl/id_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU op encodings,
// control-vector bit positions, immediate-type select and skid-buffer states.
package id_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned CTRL_W    = 9;
    localparam int unsigned ALU_ENC_W = 4;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU operation encodings
    localparam logic [ALU_ENC_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_ENC_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_ENC_W-1:0] ALU_SLL   = 4'd2;
    localparam logic [ALU_ENC_W-1:0] ALU_SLT   = 4'd3;
    localparam logic [ALU_ENC_W-1:0] ALU_SLTU  = 4'd4;
    localparam logic [ALU_ENC_W-1:0] ALU_XOR   = 4'd5;
    localparam logic [ALU_ENC_W-1:0] ALU_SRL   = 4'd6;
    localparam logic [ALU_ENC_W-1:0] ALU_SRA   = 4'd7;
    localparam logic [ALU_ENC_W-1:0] ALU_OR    = 4'd8;
    localparam logic [ALU_ENC_W-1:0] ALU_AND   = 4'd9;
    localparam logic [ALU_ENC_W-1:0] ALU_PASSB = 4'd10;

    // Control vector bit positions:
    // {illegal,pc_to_a,jump,branch,memread,memtoreg,memwrite,alusrc,regwrite}
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_ALUSRC   = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_MEMTOREG = 3;
    localparam int unsigned CTRL_MEMREAD  = 4;
    localparam int unsigned CTRL_BRANCH   = 5;
    localparam int unsigned CTRL_JUMP     = 6;
    localparam int unsigned CTRL_PC_TO_A  = 7;
    localparam int unsigned CTRL_ILLEGAL  = 8;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_e;

    // Width-fixed part of a decoded bundle
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rs1;
    } id_fields_t;

    // ALU op for OP / OP-IMM; instr[30] selects SUB (OP only) and SRA (both)
    function automatic logic [ALU_ENC_W-1:0] alu_from_funct(
        input logic [2:0] funct3,
        input logic       bit30,
        input logic       is_op
    );
        logic [ALU_ENC_W-1:0] op;
        case (funct3)
            3'b000:  op = (is_op && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_decode_pipe_imm_gen.sv
// Combinational immediate generator.
// Ports: instr  - instruction bits [31:7] (opcode bits are not needed here)
//        imm_sel - immediate format selected by the decoder
//        imm_c   - immediate sign-extended from instr[31] to XLEN (0 for IMM_NONE)
module id_imm_gen
    import id_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:7] instr,
    input  imm_sel_e           imm_sel,
    output logic [XLEN-1:0]    imm_c
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the selected format
    always_comb begin
        imm32 = '0;
        case (imm_sel)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Bit 31 of every format is instr[31], so a signed widening completes the extension
    assign imm_c = XLEN'($signed(imm32));

endmodule

// File: rtl/id_decode_pipe.sv
// Registered RV32I decode stage with valid/ready handshake and optional 2-entry skid buffer.
// Ports: clk, reset (async active-low), flush (sync kill of held and incoming beats)
//        in_valid/in_ready/in_instr/in_pc   - fetch side
//        out_valid/out_ready                - execute side handshake
//        out_pc/out_imm/out_rs1/out_rs2/out_rd/out_aluop/out_ctrl - decoded bundle
// XLEN must be >= 32.
module id_decode_pipe
    import id_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALUOP_W = 4,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_imm,
    output logic [REG_W-1:0]   out_rs1,
    output logic [REG_W-1:0]   out_rs2,
    output logic [REG_W-1:0]   out_rd,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [CTRL_W-1:0]  out_ctrl
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] aluop;
        id_fields_t         f;
    } bundle_t;

    logic [6:0]           opcode;
    logic [CTRL_W-1:0]    ctrl_c;
    logic [ALU_ENC_W-1:0] alu_c;
    imm_sel_e             imm_sel_c;
    logic [XLEN-1:0]      imm_c;
    bundle_t              new_c;

    skid_state_e state_q, state_d;
    bundle_t     main_q, main_d;
    bundle_t     skid_q, skid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept_c, drain_c;

    assign opcode = in_instr[6:0];

    // Opcode -> control vector, ALU op and immediate format
    always_comb begin
        ctrl_c    = '0;
        alu_c     = ALU_ADD;
        imm_sel_c = IMM_NONE;
        if (in_instr[1:0] != 2'b11) begin
            ctrl_c[CTRL_ILLEGAL] = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD: begin
                    ctrl_c[CTRL_MEMREAD]  = 1'b1;
                    ctrl_c[CTRL_MEMTOREG] = 1'b1;
                    ctrl_c[CTRL_ALUSRC]   = 1'b1;
                    ctrl_c[CTRL_REGWRITE] = 1'b1;
                    imm_sel_c             = IMM_I;
                end
                OPC_STORE: begin
                    ctrl_c[CTRL_MEMWRITE] = 1'b1;
                    ctrl_c[CTRL_ALUSRC]   = 1'b1;
                    imm_sel_c             = IMM_S;
                end
                OPC_OP_IMM: begin
                    ctrl_c[CTRL_ALUSRC]   = 1'b1;
                    ctrl_c[CTRL_REGWRITE] = 1'b1;
                    imm_sel_c             = IMM_I;
                    alu_c                 = alu_from_funct(in_instr[14:12], in_instr[30], 1'b0);
                end
                OPC_OP: begin
                    ctrl_c[CTRL_REGWRITE] = 1'b1;
                    alu_c                 = alu_from_funct(in_instr[14:12], in_instr[30], 1'b1);
                end
                OPC_BRANCH: begin
                    ctrl_c[CTRL_BRANCH] = 1'b1;
                    imm_sel_c           = IMM_B;
                    alu_c               = ALU_SUB;
                end
                OPC_JAL: begin
                    ctrl_c[CTRL_JUMP]     = 1'b1;
                    ctrl_c[CTRL_PC_TO_A]  = 1'b1;
                    ctrl_c[CTRL_REGWRITE] = 1'b1;
                    imm_sel_c             = IMM_J;
                end
                OPC_JALR: begin
                    ctrl_c[CTRL_JUMP]     = 1'b1;
                    ctrl_c[CTRL_ALUSRC]   = 1'b1;
                    ctrl_c[CTRL_REGWRITE] = 1'b1;
                    imm_sel_c             = IMM_I;
                end
                OPC_LUI: begin
                    ctrl_c[CTRL_ALUSRC]   = 1'b1;
                    ctrl_c[CTRL_REGWRITE] = 1'b1;
                    imm_sel_c             = IMM_U;
                    alu_c                 = ALU_PASSB;
                end
                OPC_AUIPC: begin
                    ctrl_c[CTRL_PC_TO_A]  = 1'b1;
                    ctrl_c[CTRL_ALUSRC]   = 1'b1;
                    ctrl_c[CTRL_REGWRITE] = 1'b1;
                    imm_sel_c             = IMM_U;
                end
                default: ctrl_c[CTRL_ILLEGAL] = 1'b1;
            endcase
        end
    end

    id_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr   (in_instr[INSTR_W-1:7]),
        .imm_sel (imm_sel_c),
        .imm_c   (imm_c)
    );

    // Bundle that would be captured on accept
    always_comb begin
        new_c        = '0;
        new_c.pc     = in_pc;
        new_c.imm    = imm_c;
        new_c.aluop  = ALUOP_W'(alu_c);
        new_c.f.ctrl = ctrl_c;
        new_c.f.rd   = in_instr[11:7];
        new_c.f.rs2  = in_instr[24:20];
        new_c.f.rs1  = in_instr[19:15];
    end

    // Without the skid entry, ready follows the classic pipeline-register rule
    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready = in_ready_q;
        end else begin : g_pipe_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign accept_c = in_valid && in_ready;
    assign drain_c  = out_valid && out_ready;

    // Skid-buffer next state; TWO is unreachable when SKID_EN=0 since in_ready blocks ONE->TWO
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        main_d  = new_c;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_c && drain_c) begin
                        main_d = new_c;
                    end else if (accept_c) begin
                        skid_d  = new_c;
                        state_d = ST_TWO;
                    end else if (drain_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain_c) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    // State and storage registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_pc    = main_q.pc;
    assign out_imm   = main_q.imm;
    assign out_aluop = main_q.aluop;
    assign out_ctrl  = main_q.f.ctrl;
    assign out_rd    = main_q.f.rd;
    assign out_rs1   = main_q.f.rs1;
    assign out_rs2   = main_q.f.rs2;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed and randomised-handshake bench for id_decode_pipe.
module tb_id_decode_pipe;

    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [3:0]  out_aluop;
    logic [8:0]  out_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_decode_pipe #(
        .XLEN    (XLEN),
        .ALUOP_W (4),
        .SKID_EN (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_imm   (out_imm),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_rd    (out_rd),
        .out_aluop (out_aluop),
        .out_ctrl  (out_ctrl)
    );

    // Observed bundle: {pc, imm, aluop, ctrl, rd, rs1, rs2}
    logic [91:0] obs;
    assign obs = {out_pc, out_imm, out_aluop, out_ctrl, out_rd, out_rs1, out_rs2};

    function automatic logic [31:0] pool_instr(input int i);
        case (i)
            0:  return 32'hFFF00093; // addi x1,x0,-1
            1:  return 32'hFE000EE3; // beq x0,x0,-4
            2:  return 32'h000002B7; // lui x5,0
            3:  return 32'h0000007F; // unknown opcode
            4:  return 32'h00000000; // instr[1:0]!=11
            5:  return 32'h402081B3; // sub x3,x1,x2
            6:  return 32'hFF812303; // lw x6,-8(x2)
            7:  return 32'h00712623; // sw x7,12(x2)
            8:  return 32'hFF1FF0EF; // jal x1,-16
            9:  return 32'h4032D213; // srai x4,x5,3
            10: return 32'h80000517; // auipc x10,0x80000
            11: return 32'h00008067; // jalr x0,0(x1)
            default: return 32'h00A4F433; // and x8,x9,x10
        endcase
    endfunction

    // Hand-decoded expectations: {imm, aluop, ctrl, rd, rs1, rs2}
    function automatic logic [59:0] pool_exp(input int i);
        case (i)
            0:  return {32'hFFFFFFFF, 4'd0,  9'h003, 5'd1,  5'd0,  5'd31};
            1:  return {32'hFFFFFFFC, 4'd1,  9'h020, 5'd29, 5'd0,  5'd0};
            2:  return {32'h00000000, 4'd10, 9'h003, 5'd5,  5'd0,  5'd0};
            3:  return {32'h00000000, 4'd0,  9'h100, 5'd0,  5'd0,  5'd0};
            4:  return {32'h00000000, 4'd0,  9'h100, 5'd0,  5'd0,  5'd0};
            5:  return {32'h00000000, 4'd1,  9'h001, 5'd3,  5'd1,  5'd2};
            6:  return {32'hFFFFFFF8, 4'd0,  9'h01B, 5'd6,  5'd2,  5'd24};
            7:  return {32'h0000000C, 4'd0,  9'h006, 5'd12, 5'd2,  5'd7};
            8:  return {32'hFFFFFFF0, 4'd0,  9'h0C1, 5'd1,  5'd31, 5'd17};
            9:  return {32'h00000403, 4'd7,  9'h003, 5'd4,  5'd5,  5'd3};
            10: return {32'h80000000, 4'd0,  9'h083, 5'd10, 5'd0,  5'd0};
            11: return {32'h00000000, 4'd0,  9'h043, 5'd0,  5'd1,  5'd0};
            default: return {32'h00000000, 4'd9, 9'h001, 5'd8, 5'd9, 5'd10};
        endcase
    endfunction

    task automatic drive(input logic v, input int idx, input logic [31:0] pc);
        in_valid = v;
        in_instr = pool_instr(idx);
        in_pc    = pc;
    endtask

    task automatic test_reset;
        logic [91:0] exp;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== 92'd0) begin
            n_fail++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b obs=%h, required 1 0 0", in_ready, out_valid, obs);
        end
        out_ready = 1'b0;
        drive(1'b1, 0, 32'h40);
        @(negedge clk);
        in_valid = 1'b0;
        exp = {32'h40, pool_exp(0)};
        n_checks++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL reset_prefill: out_valid=%b obs=%h, required 1 %h", out_valid, obs, exp);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || obs !== 92'd0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b obs=%h, required 0 0", out_valid, obs);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_addi;
        logic [91:0] exp;
        out_ready = 1'b1;
        drive(1'b1, 0, 32'h100);
        @(negedge clk);
        in_valid = 1'b0;
        exp = {32'h100, pool_exp(0)};
        n_checks++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL addi: out_valid=%b obs=%h, required 1 %h", out_valid, obs, exp);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_drained: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_branch_lui;
        logic [91:0] exp;
        out_ready = 1'b1;
        drive(1'b1, 1, 32'h120);
        @(negedge clk);
        drive(1'b1, 2, 32'h124);
        exp = {32'h120, pool_exp(1)};
        n_checks++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL beq: out_valid=%b obs=%h, required 1 %h", out_valid, obs, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        exp = {32'h124, pool_exp(2)};
        n_checks++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL lui: out_valid=%b obs=%h, required 1 %h", out_valid, obs, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [91:0] exp;
        int got;
        logic take_in;
        out_ready = 1'b0;
        drive(1'b1, 0, 32'h200);
        @(negedge clk);
        drive(1'b1, 2, 32'h204);
        @(negedge clk);
        drive(1'b1, 12, 32'h208);
        exp = {32'h200, pool_exp(0)};
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_full: in_ready=%b out_valid=%b obs=%h, required 0 1 %h", in_ready, out_valid, obs, exp);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_hold: in_ready=%b obs=%h, required 0 %h", in_ready, obs, exp);
        end
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            take_in = in_valid && in_ready;
            if (out_valid) begin
                case (got)
                    0:       exp = {32'h200, pool_exp(0)};
                    1:       exp = {32'h204, pool_exp(2)};
                    default: exp = {32'h208, pool_exp(12)};
                endcase
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: obs=%h, required %h", got, obs, exp);
                end
                got++;
            end
            @(negedge clk);
            if (take_in) in_valid = 1'b0;
        end
        n_checks++;
        if (got != 3 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: got=%0d out_valid=%b, required 3 0", got, out_valid);
        end
    endtask

    task automatic test_flush;
        logic seen;
        out_ready = 1'b0;
        drive(1'b1, 5, 32'h300);
        @(negedge clk);
        drive(1'b1, 6, 32'h304);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_prefill: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        drive(1'b1, 7, 32'h308);
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_two: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ghost: out_valid seen=%b, required 0", seen);
        end
        // Flush in ONE while a new beat would otherwise be accepted
        drive(1'b1, 8, 32'h30C);
        @(negedge clk);
        drive(1'b1, 9, 32'h310);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_one_incoming: out_valid=%b obs=%h, required 0", out_valid, obs);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        logic [91:0] exp;
        out_ready = 1'b1;
        drive(1'b1, 3, 32'h400);
        @(negedge clk);
        drive(1'b1, 4, 32'h404);
        exp = {32'h400, pool_exp(3)};
        n_checks++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL illegal_opcode: out_valid=%b obs=%h, required 1 %h", out_valid, obs, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        exp = {32'h404, pool_exp(4)};
        n_checks++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL illegal_low_bits: out_valid=%b obs=%h, required 1 %h", out_valid, obs, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_soak;
        int          q_idx[$];
        logic [31:0] q_pc[$];
        logic [31:0] pc;
        logic [91:0] exp;
        int          cur;
        int          e_idx;
        logic [31:0] e_pc;
        pc = 32'h1000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            flush     = ($urandom_range(0, 29) == 0);
            cur       = int'($urandom_range(0, 12));
            drive($urandom_range(0, 2) != 0, cur, pc);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (flush) begin
                q_idx.delete();
                q_pc.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (q_idx.size() == 0) begin
                        n_fail++;
                        $display("FAIL soak_unexpected: obs=%h, required no output", obs);
                    end else begin
                        e_idx = q_idx.pop_front();
                        e_pc  = q_pc.pop_front();
                        exp   = {e_pc, pool_exp(e_idx)};
                        if (obs !== exp) begin
                            n_fail++;
                            $display("FAIL soak_data: obs=%h, required %h", obs, exp);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    q_idx.push_back(cur);
                    q_pc.push_back(pc);
                    pc = pc + 32'd4;
                end
            end
        end
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8 && q_idx.size() != 0; k++) begin
            #1;
            if (out_valid) begin
                e_idx = q_idx.pop_front();
                e_pc  = q_pc.pop_front();
                exp   = {e_pc, pool_exp(e_idx)};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL soak_drain_data: obs=%h, required %h", obs, exp);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (q_idx.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL soak_drain: left=%0d out_valid=%b, required 0 0", q_idx.size(), out_valid);
        end
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        test_reset();
        test_addi();
        test_branch_lui();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
